rf_write_arbiter: RTL



---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/rf_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter and its scoreboard.
package rf_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    // One writeback requester: request flag, destination and result.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback; x0 never pending.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic [NREG-1:0]      pending
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Clear first, then set, so a new producer issued in the same cycle supersedes the old one.
    always_comb begin
        pending_d = pending_q;
        if (clr_en && (clr_idx != '0)) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths.
// MEM has fixed priority; after MAX_WAIT consecutive lost arbitrations the ALU is
// forced to win. Handshake: a source transfers in a cycle where valid && ready;
// ready depends only on the valids, reset and the starve counter, at most one
// ready is high per cycle, and a requester holds valid/rd/data until accepted.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN_P   = rf_pkg::XLEN,
    parameter int MAX_WAIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN_P-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN_P-1:0]    mem_data,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic [NREG-1:0]      pending,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN_P-1:0]    rf_wdata
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t win_req;
    logic    force_alu;
    logic    alu_acc;
    logic    mem_acc;
    logic    accept;

    logic [3:0]           starve_q;
    logic [3:0]           starve_d;
    logic                 rf_we_q;
    logic                 rf_we_d;
    logic [REG_IDX_W-1:0] rf_rd_q;
    logic [REG_IDX_W-1:0] rf_rd_d;
    logic [XLEN_P-1:0]    rf_wdata_q;
    logic [XLEN_P-1:0]    rf_wdata_d;

    // Grant: MEM wins contention unless the ALU has waited MAX_WAIT times in a row.
    always_comb begin
        alu_req   = '{valid: alu_valid, rd: alu_rd, data: alu_data};
        mem_req   = '{valid: mem_valid, rd: mem_rd, data: mem_data};
        force_alu = (starve_q == MAX_W);
        alu_ready = !reset && alu_req.valid && (!mem_req.valid || force_alu);
        mem_ready = !reset && mem_req.valid && !(alu_req.valid && force_alu);
        alu_acc   = alu_req.valid && alu_ready;
        mem_acc   = mem_req.valid && mem_ready;
        accept    = alu_acc || mem_acc;
        win_req   = alu_acc ? alu_req : mem_req;
    end

    // Starve counter and next write-port values.
    always_comb begin
        starve_d   = '0;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_valid && !alu_ready) begin
            starve_d = (starve_q == MAX_W) ? starve_q : starve_q + 4'd1;
        end
        if (accept) begin
            rf_rd_d    = win_req.rd;
            rf_wdata_d = win_req.data;
            rf_we_d    = (win_req.rd != '0);
        end
    end

    // Registered write port and starve counter; reset drops any write in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

    rf_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (issue_valid),
        .set_idx (issue_rd),
        .clr_en  (accept),
        .clr_idx (win_req.rd),
        .pending (pending)
    );

endmodule
